// File: rtl/dwt_pkg.sv
// Shared definitions for the Haar DWT datapath: default widths, the sample ROM
// image and the per-pair Haar arithmetic reused by the 1-D and 2-D blocks.
package dwt_pkg;

  localparam int DWT_DATA_W  = 8;
  localparam int HIGH_OFFSET = 128;
  localparam int ROM_DEF_LEN = 16;

  localparam logic [DWT_DATA_W-1:0] DEFAULT_ROM [ROM_DEF_LEN] = '{
    8'd52, 8'd60, 8'd61, 8'd55, 8'd80, 8'd80, 8'd200, 8'd100,
    8'd0, 8'd255, 8'd255, 8'd0, 8'd17, 8'd16, 8'd128, 8'd129
  };

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } dwt_state_t;

  // Returns {low, high}. floor((a+b)/2) and floor((a-b)/2) are rebuilt from the
  // halved operands plus an LSB correction, so everything stays DATA_W wide;
  // adding HIGH_OFFSET modulo 2^DATA_W maps the signed detail to offset-binary.
  function automatic logic [2*DWT_DATA_W-1:0] haar_pair(
    input logic [DWT_DATA_W-1:0] a,
    input logic [DWT_DATA_W-1:0] b
  );
    logic [DWT_DATA_W-1:0] a_half;
    logic [DWT_DATA_W-1:0] b_half;
    logic [DWT_DATA_W-1:0] low;
    logic [DWT_DATA_W-1:0] high;
    a_half = a >> 1;
    b_half = b >> 1;
    low  = a_half + b_half + {{(DWT_DATA_W-1){1'b0}}, a[0] & b[0]};
    high = a_half - b_half - {{(DWT_DATA_W-1){1'b0}}, ~a[0] & b[0]}
           + DWT_DATA_W'(HIGH_OFFSET);
    return {low, high};
  endfunction

endpackage

// File: rtl/dwt_sample_rom.sv
// Fixed sample ROM with two combinational read ports returning the even and
// odd sample of a pair, addressed by pair index.
module dwt_sample_rom
  import dwt_pkg::*;
#(
  parameter int N_SAMPLES = 16,
  parameter int DATA_W    = DWT_DATA_W,
  parameter int K_W       = 3
) (
  input  logic [K_W-1:0]    pair_idx,
  output logic [DATA_W-1:0] sample_even,
  output logic [DATA_W-1:0] sample_odd
);

  logic [DATA_W-1:0] rom_mem [N_SAMPLES];
  logic [K_W:0]      addr_even;
  logic [K_W:0]      addr_odd;

  // Entries beyond the default image read as zero.
  generate
    for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_rom
      if (gi < ROM_DEF_LEN) begin : g_init
        assign rom_mem[gi] = DATA_W'(DEFAULT_ROM[gi]);
      end else begin : g_zero
        assign rom_mem[gi] = '0;
      end
    end
  endgenerate

  assign addr_even   = {pair_idx, 1'b0};
  assign addr_odd    = {pair_idx, 1'b1};
  assign sample_even = rom_mem[addr_even];
  assign sample_odd  = rom_mem[addr_odd];

endmodule

// File: rtl/dwt_1d_1l.sv
// One-level 1-D integer Haar DWT over the internal sample ROM: one
// (low, high) coefficient pair per clock, registered outputs, optional looping.
module dwt_1d_1l
  import dwt_pkg::*;
#(
  parameter int N_SAMPLES = 16,
  parameter int DATA_W    = DWT_DATA_W,
  parameter int LOOP      = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  output logic [DATA_W-1:0] low_o,
  output logic [DATA_W-1:0] high_o,
  output logic              valid_o,
  output logic              done_o
);

  localparam int N_PAIRS = N_SAMPLES / 2;
  localparam int K_W     = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam logic [K_W-1:0] LAST_K = K_W'(N_PAIRS - 1);

  dwt_state_t        state_reg, state_next;
  logic [K_W-1:0]    k_reg, k_next;
  logic [DATA_W-1:0] low_reg, low_next;
  logic [DATA_W-1:0] high_reg, high_next;
  logic              valid_reg, valid_next;
  logic              done_reg, done_next;

  logic [DATA_W-1:0] sample_a;
  logic [DATA_W-1:0] sample_b;
  logic [DATA_W-1:0] coef_low;
  logic [DATA_W-1:0] coef_high;
  logic              last_pair;

  dwt_sample_rom #(
    .N_SAMPLES (N_SAMPLES),
    .DATA_W    (DATA_W),
    .K_W       (K_W)
  ) u_rom (
    .pair_idx    (k_reg),
    .sample_even (sample_a),
    .sample_odd  (sample_b)
  );

  generate
    if (DATA_W == DWT_DATA_W) begin : g_pkg_haar
      assign {coef_low, coef_high} = haar_pair(sample_a, sample_b);
    end else begin : g_wide_haar
      // Same halved-operand identity as haar_pair, at this instance's width.
      logic [DATA_W-1:0] a_half;
      logic [DATA_W-1:0] b_half;
      assign a_half    = sample_a >> 1;
      assign b_half    = sample_b >> 1;
      assign coef_low  = a_half + b_half
                         + {{(DATA_W-1){1'b0}}, sample_a[0] & sample_b[0]};
      assign coef_high = a_half - b_half
                         - {{(DATA_W-1){1'b0}}, ~sample_a[0] & sample_b[0]}
                         + {1'b1, {(DATA_W-1){1'b0}}};
    end
  endgenerate

  assign last_pair = (k_reg == LAST_K);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= ST_RUN;
      k_reg     <= '0;
      low_reg   <= '0;
      high_reg  <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      low_reg   <= low_next;
      high_reg  <= high_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
    end
  end

  // Next state and pair index; in ST_DONE the index stays saturated.
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    case (state_reg)
      ST_RUN: begin
        if (last_pair) begin
          if (LOOP != 0) begin
            k_next = '0;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_comb begin
    low_next   = low_reg;
    high_next  = high_reg;
    valid_next = 1'b0;
    done_next  = done_reg;
    case (state_reg)
      ST_RUN: begin
        low_next   = coef_low;
        high_next  = coef_high;
        valid_next = 1'b1;
        done_next  = (LOOP != 0) && last_pair;
      end
      ST_DONE: begin
        done_next = 1'b1;
      end
      default: begin
        done_next = 1'b0;
      end
    endcase
  end

  assign low_o   = low_reg;
  assign high_o  = high_reg;
  assign valid_o = valid_reg;
  assign done_o  = done_reg;

endmodule

// File: tb/tb_dwt_1d_1l.sv
// Directed bench for dwt_1d_1l: one LOOP=0 and one LOOP=1 instance checked
// against hand-computed Haar coefficients of the default ROM.
module tb_dwt_1d_1l;

  logic       clk = 1'b0;
  logic       rst0 = 1'b1;
  logic       rst1 = 1'b1;
  logic [7:0] low0, high0, low1, high1;
  logic       valid0, done0, valid1, done1;

  int vectors = 0;
  int miscompares = 0;

  int exp_low  [8] = '{56, 58, 80, 150, 127, 127, 16, 128};
  int exp_high [8] = '{124, 131, 128, 178, 0, 255, 128, 127};

  always #5 clk = ~clk;

  dwt_1d_1l #(.N_SAMPLES(16), .DATA_W(8), .LOOP(0)) dut0 (
    .sys_clk (clk),
    .sys_rst (rst0),
    .low_o   (low0),
    .high_o  (high0),
    .valid_o (valid0),
    .done_o  (done0)
  );

  dwt_1d_1l #(.N_SAMPLES(16), .DATA_W(8), .LOOP(1)) dut1 (
    .sys_clk (clk),
    .sys_rst (rst1),
    .low_o   (low1),
    .high_o  (high1),
    .valid_o (valid1),
    .done_o  (done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_dut0(input string tag, input int lo, input int hi,
                            input logic v, input logic d);
    check({tag, ".low"},   {24'd0, low0},   lo);
    check({tag, ".high"},  {24'd0, high0},  hi);
    check({tag, ".valid"}, {31'd0, valid0}, {31'd0, v});
    check({tag, ".done"},  {31'd0, done0},  {31'd0, d});
    $display("t=%0t %s low=%0d high=%0d valid=%0b done=%0b", $time, tag, low0, high0, valid0, done0);
  endtask

  task automatic check_dut1(input string tag, input int lo, input int hi,
                            input logic v, input logic d);
    check({tag, ".low"},   {24'd0, low1},   lo);
    check({tag, ".high"},  {24'd0, high1},  hi);
    check({tag, ".valid"}, {31'd0, valid1}, {31'd0, v});
    check({tag, ".done"},  {31'd0, done1},  {31'd0, d});
    $display("t=%0t %s low=%0d high=%0d valid=%0b done=%0b", $time, tag, low1, high1, valid1, done1);
  endtask

  initial begin
    // Reset hold for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_dut0($sformatf("reset_hold%0d", i), 0, 0, 1'b0, 1'b0);
    end

    // Full sequence, LOOP=0.
    rst0 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check_dut0($sformatf("pair%0d", n), exp_low[n], exp_high[n], 1'b1, 1'b0);
    end

    // Termination: outputs hold the last pair with done set.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_dut0($sformatf("term%0d", i), 128, 127, 1'b0, 1'b1);
    end

    // Mid-run reset after pair 3.
    rst0 = 1'b1;
    @(negedge clk);
    check_dut0("rerun_reset", 0, 0, 1'b0, 1'b0);
    rst0 = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_dut0($sformatf("rerun_pair%0d", n), exp_low[n], exp_high[n], 1'b1, 1'b0);
    end
    rst0 = 1'b1;
    @(negedge clk);
    check_dut0("midrun_reset", 0, 0, 1'b0, 1'b0);
    rst0 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check_dut0($sformatf("restart_pair%0d", n), exp_low[n], exp_high[n], 1'b1, 1'b0);
    end
    @(negedge clk);
    check_dut0("restart_done", 128, 127, 1'b0, 1'b1);

    // LOOP=1: the held-in-reset instance starts now and wraps with period 8.
    check_dut1("loop_reset", 0, 0, 1'b0, 1'b0);
    rst1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_dut1($sformatf("loop%0d_pair%0d", i, i % 8), exp_low[i % 8], exp_high[i % 8],
                 1'b1, (i % 8) == 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
